// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC control unit and its helpers.
package pc_ctrl_pkg;

    // ID-stage opcodes that can redirect the front end
    localparam logic [5:0] OP_BZ  = 6'd10;
    localparam logic [5:0] OP_BGZ = 6'd11;
    localparam logic [5:0] OP_BLZ = 6'd12;
    localparam logic [5:0] OP_JR  = 6'd13;
    localparam logic [5:0] OP_J   = 6'd14;
    localparam logic [5:0] OP_CLL = 6'd15;

    // What kind of PC redirect is being requested
    typedef enum logic [2:0] {
        RK_NONE   = 3'd0,
        RK_BRANCH = 3'd1,
        RK_JUMP   = 3'd2,
        RK_CALL   = 3'd3,
        RK_JR     = 3'd4
    } redirect_kind_t;

    // Front-end sequencing state
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } pcc_state_t;

endpackage

// File: rtl/pc_control_unit_if.sv
// Decode/hazard inputs and PC/pipeline-register controls of the PC control unit.
interface pc_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 16
);
    logic                id_valid;
    logic [OPCODE_W-1:0] id_opcode;
    logic [13:0]         id_imm14;
    logic [31:0]         rs_value;
    logic                load_use_hazard;
    logic                mem_stall;

    logic                pc_write;
    logic                branch;
    logic                jump;
    logic                jr;
    logic [13:0]         offset;
    logic [13:0]         target;
    logic [31:0]         jump_addr;
    logic                link_we;
    logic                if_id_write;
    logic                if_id_flush;
    logic                id_ex_bubble;
    logic [CNT_W-1:0]    redirect_count;
    logic [CNT_W-1:0]    stall_count;

    // Decode/hazard side: drives ID information, observes PC controls
    modport master (
        output id_valid, id_opcode, id_imm14, rs_value, load_use_hazard, mem_stall,
        input  pc_write, branch, jump, jr, offset, target, jump_addr, link_we,
        input  if_id_write, if_id_flush, id_ex_bubble, redirect_count, stall_count
    );

    // PC control unit side
    modport slave (
        input  id_valid, id_opcode, id_imm14, rs_value, load_use_hazard, mem_stall,
        output pc_write, branch, jump, jr, offset, target, jump_addr, link_we,
        output if_id_write, if_id_flush, id_ex_bubble, redirect_count, stall_count
    );
endinterface

// File: rtl/branch_resolver.sv
// Combinational redirect resolution: opcode plus Rs value to redirect kind.
// Kept standalone so an EX-stage checker can reuse the same decision.
module branch_resolver
    import pc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic                valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [31:0]         rs_value,
    output redirect_kind_t      kind
);

    logic rs_zero_s;
    logic rs_neg_s;
    logic rs_pos_s;

    assign rs_zero_s = (rs_value == 32'd0);
    assign rs_neg_s  = rs_value[31];
    assign rs_pos_s  = !rs_zero_s && !rs_neg_s;

    // Select the redirect kind for a valid ID instruction
    always_comb begin
        kind = RK_NONE;
        if (valid) begin
            case (opcode)
                OPCODE_W'(OP_BZ):  kind = rs_zero_s ? RK_BRANCH : RK_NONE;
                OPCODE_W'(OP_BGZ): kind = rs_pos_s  ? RK_BRANCH : RK_NONE;
                OPCODE_W'(OP_BLZ): kind = rs_neg_s  ? RK_BRANCH : RK_NONE;
                OPCODE_W'(OP_JR):  kind = RK_JR;
                OPCODE_W'(OP_J):   kind = RK_JUMP;
                OPCODE_W'(OP_CLL): kind = RK_CALL;
                default:           kind = RK_NONE;
            endcase
        end else begin
            kind = RK_NONE;
        end
    end

endmodule

// File: rtl/pc_control_unit.sv
// PC control unit: resolves ID-stage redirects, sequences load-use and
// memory stalls, holds a redirect across a memory stall and squashes the
// wrong-path fetches still in flight from instruction memory.
module pc_control_unit
    import pc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int IMEM_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    pc_control_unit_if.slave        bus
);

    localparam logic [1:0] FLUSH_LOAD = 2'(IMEM_LAT - 1);
    localparam bit         USE_FLUSH  = (IMEM_LAT > 1);

    redirect_kind_t   id_kind_s;

    pcc_state_t       state_r;
    pcc_state_t       state_nx_s;
    redirect_kind_t   hold_kind_r;
    redirect_kind_t   hold_kind_nx_s;
    logic [13:0]      hold_imm_r;
    logic [13:0]      hold_imm_nx_s;
    logic [31:0]      hold_rs_r;
    logic [31:0]      hold_rs_nx_s;
    logic [1:0]       flush_cnt_r;
    logic [1:0]       flush_cnt_nx_s;
    logic [CNT_W-1:0] redirect_count_r;
    logic [CNT_W-1:0] stall_count_r;

    redirect_kind_t   issue_kind_s;
    logic [13:0]      issue_imm_s;
    logic [31:0]      issue_rs_s;
    logic             pc_write_s;
    logic             if_id_write_s;
    logic             if_id_flush_s;
    logic             id_ex_bubble_s;
    logic             redirect_inc_s;
    logic             stall_inc_s;
    logic             branch_s;
    logic             jump_s;
    logic             jr_s;
    logic             link_we_s;

    branch_resolver #(
        .OPCODE_W (OPCODE_W)
    ) u_resolver (
        .valid    (bus.id_valid),
        .opcode   (bus.id_opcode),
        .rs_value (bus.rs_value),
        .kind     (id_kind_s)
    );

    // Next-state and control decode; mem_stall outranks load-use, which outranks redirects
    always_comb begin
        state_nx_s     = state_r;
        hold_kind_nx_s = hold_kind_r;
        hold_imm_nx_s  = hold_imm_r;
        hold_rs_nx_s   = hold_rs_r;
        flush_cnt_nx_s = flush_cnt_r;
        issue_kind_s   = RK_NONE;
        issue_imm_s    = bus.id_imm14;
        issue_rs_s     = bus.rs_value;
        pc_write_s     = 1'b0;
        if_id_write_s  = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        redirect_inc_s = 1'b0;
        stall_inc_s    = 1'b0;

        if (!reset) begin
            // Hold the front end quiet and keep IF/ID cleared until release
            if_id_flush_s  = 1'b1;
            issue_imm_s    = 14'd0;
            issue_rs_s     = 32'd0;
            state_nx_s     = RUN;
            hold_kind_nx_s = RK_NONE;
            hold_imm_nx_s  = 14'd0;
            hold_rs_nx_s   = 32'd0;
            flush_cnt_nx_s = 2'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (bus.mem_stall) begin
                        stall_inc_s = 1'b1;
                        if (id_kind_s != RK_NONE) begin
                            hold_kind_nx_s = id_kind_s;
                            hold_imm_nx_s  = bus.id_imm14;
                            hold_rs_nx_s   = bus.rs_value;
                            state_nx_s     = HOLD;
                        end else begin
                            state_nx_s     = RUN;
                        end
                    end else if (bus.load_use_hazard) begin
                        id_ex_bubble_s = 1'b1;
                        stall_inc_s    = 1'b1;
                    end else if (id_kind_s != RK_NONE) begin
                        issue_kind_s   = id_kind_s;
                        pc_write_s     = 1'b1;
                        if_id_flush_s  = 1'b1;
                        redirect_inc_s = 1'b1;
                        if (USE_FLUSH) begin
                            state_nx_s     = FLUSH;
                            flush_cnt_nx_s = FLUSH_LOAD;
                        end else begin
                            state_nx_s     = RUN;
                        end
                    end else begin
                        pc_write_s    = 1'b1;
                        if_id_write_s = 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.mem_stall) begin
                        stall_inc_s = 1'b1;
                    end else begin
                        // Issue the saved redirect; current ID contents are wrong-path
                        issue_kind_s   = hold_kind_r;
                        issue_imm_s    = hold_imm_r;
                        issue_rs_s     = hold_rs_r;
                        pc_write_s     = 1'b1;
                        if_id_flush_s  = 1'b1;
                        redirect_inc_s = 1'b1;
                        hold_kind_nx_s = RK_NONE;
                        hold_imm_nx_s  = 14'd0;
                        hold_rs_nx_s   = 32'd0;
                        if (USE_FLUSH) begin
                            state_nx_s     = FLUSH;
                            flush_cnt_nx_s = FLUSH_LOAD;
                        end else begin
                            state_nx_s     = RUN;
                        end
                    end
                end
                FLUSH: begin
                    if_id_flush_s = 1'b1;
                    if (bus.mem_stall) begin
                        stall_inc_s = 1'b1;
                    end else begin
                        pc_write_s     = 1'b1;
                        flush_cnt_nx_s = flush_cnt_r - 2'd1;
                        if (flush_cnt_r <= 2'd1) begin
                            state_nx_s     = RUN;
                            flush_cnt_nx_s = 2'd0;
                        end else begin
                            state_nx_s     = FLUSH;
                        end
                    end
                end
                default: begin
                    state_nx_s     = RUN;
                    hold_kind_nx_s = RK_NONE;
                    flush_cnt_nx_s = 2'd0;
                end
            endcase
        end
    end

    // Encode the issued redirect kind onto the one-hot PC select lines
    always_comb begin
        branch_s  = 1'b0;
        jump_s    = 1'b0;
        jr_s      = 1'b0;
        link_we_s = 1'b0;
        case (issue_kind_s)
            RK_BRANCH: branch_s = 1'b1;
            RK_JUMP:   jump_s   = 1'b1;
            RK_CALL: begin
                jump_s    = 1'b1;
                link_we_s = 1'b1;
            end
            RK_JR:     jr_s     = 1'b1;
            default: begin
                branch_s  = 1'b0;
                jump_s    = 1'b0;
                jr_s      = 1'b0;
                link_we_s = 1'b0;
            end
        endcase
    end

    // State, pending-redirect latch and flush count
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= RUN;
            hold_kind_r <= RK_NONE;
            hold_imm_r  <= 14'd0;
            hold_rs_r   <= 32'd0;
            flush_cnt_r <= 2'd0;
        end else begin
            state_r     <= state_nx_s;
            hold_kind_r <= hold_kind_nx_s;
            hold_imm_r  <= hold_imm_nx_s;
            hold_rs_r   <= hold_rs_nx_s;
            flush_cnt_r <= flush_cnt_nx_s;
        end
    end

    // Saturating performance counters; they stick at all-ones
    always_ff @(posedge clk) begin
        if (!reset) begin
            redirect_count_r <= {CNT_W{1'b0}};
            stall_count_r    <= {CNT_W{1'b0}};
        end else begin
            if (redirect_inc_s && (redirect_count_r != {CNT_W{1'b1}})) begin
                redirect_count_r <= redirect_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                redirect_count_r <= redirect_count_r;
            end
            if (stall_inc_s && (stall_count_r != {CNT_W{1'b1}})) begin
                stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign bus.pc_write       = pc_write_s;
    assign bus.branch         = branch_s;
    assign bus.jump           = jump_s;
    assign bus.jr             = jr_s;
    assign bus.link_we        = link_we_s;
    assign bus.offset         = issue_imm_s;
    assign bus.target         = issue_imm_s;
    assign bus.jump_addr      = issue_rs_s;
    assign bus.if_id_write    = if_id_write_s;
    assign bus.if_id_flush    = if_id_flush_s;
    assign bus.id_ex_bubble   = id_ex_bubble_s;
    assign bus.redirect_count = redirect_count_r;
    assign bus.stall_count    = stall_count_r;

endmodule
